// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared types and helpers for the core-array memory arbiter.
// Kept separate so the round-robin picker can be reused by other arbiters.
package wb_arb_pkg;

  typedef enum logic {
    IDLE,
    BUSY
  } arb_state_t;

  localparam int GNT_W  = 3;
  localparam int WCNT_W = 16;

  // (a + b) mod n without relying on n being a power of two.
  // Callers keep a < n and b < n, so one subtraction is enough.
  function automatic logic [GNT_W-1:0] mod_add(
    input logic [GNT_W-1:0] a,
    input int               b,
    input int               n
  );
    int s;
    s = int'(a) + b;
    if (s >= n) begin
      s = s - n;
    end
    return GNT_W'(s);
  endfunction

endpackage

// File: rtl/wb_mem_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
// Returns the first set request at or above ptr, wrapping at NUM_CORES.
module rr_pick
  import wb_arb_pkg::*;
#(
  parameter int NUM_CORES = 6
) (
  input  logic [NUM_CORES-1:0] req,
  input  logic [GNT_W-1:0]     ptr,
  output logic [GNT_W-1:0]     winner,
  output logic                 any
);

  logic [GNT_W-1:0] idx;

  // Scan from the farthest offset down so the nearest requester is kept.
  always_comb begin
    idx    = '0;
    winner = '0;
    any    = |req;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      idx = mod_add(ptr, i, NUM_CORES);
      if (req[idx]) begin
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/wb_mem_arbiter.sv
// wb_mem_arbiter: round-robin Wishbone-classic arbiter, N cores to one memory.
// Grant is held until ack, abort or watchdog; one IDLE cycle between grants.
module wb_mem_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_CORES = 6,
  parameter int TIMEOUT   = 1024
) (
  input  logic                        clk_n,
  input  logic                        reset,
  input  logic [NUM_CORES-1:0][31:2]  m_adr,
  input  logic [NUM_CORES-1:0][31:0]  m_dat,
  input  logic [NUM_CORES-1:0][3:0]   m_sel,
  input  logic [NUM_CORES-1:0]        m_we,
  input  logic [NUM_CORES-1:0]        m_cyc,
  output logic [NUM_CORES-1:0][31:0]  m_rdt,
  output logic [NUM_CORES-1:0]        m_ack,
  output logic [31:2]                 s_adr,
  output logic [31:0]                 s_dat,
  output logic [3:0]                  s_sel,
  output logic                        s_we,
  output logic                        s_cyc,
  input  logic [31:0]                 s_rdt,
  input  logic                        s_ack,
  output logic [2:0]                  gnt_id,
  output logic                        wdog_err
);

  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);

  arb_state_t        state_q, state_d;
  logic [GNT_W-1:0]  ptr_q, ptr_d;
  logic [GNT_W-1:0]  gnt_q, gnt_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              wdog_q, wdog_d;
  logic [GNT_W-1:0]  winner;
  logic              any_req;
  logic              gnt_cyc;
  logic              wdog_hit;

  rr_pick #(
    .NUM_CORES(NUM_CORES)
  ) u_pick (
    .req   (m_cyc),
    .ptr   (ptr_q),
    .winner(winner),
    .any   (any_req)
  );

  assign gnt_cyc  = m_cyc[gnt_q];
  assign wdog_hit = (wcnt_q == WCNT_LAST);

  // Next state: grant from IDLE; in BUSY end on ack, abort or timeout.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    wcnt_d  = wcnt_q;
    wdog_d  = wdog_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = BUSY;
          gnt_d   = winner;
          wcnt_d  = '0;
        end
      end
      BUSY: begin
        if (s_ack || !gnt_cyc || wdog_hit) begin
          state_d = IDLE;
          ptr_d   = mod_add(gnt_q, 1, NUM_CORES);
          if (!s_ack && gnt_cyc) begin
            wdog_d = 1'b1;
          end
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Bus steering: mux the granted master out, route ack/data back.
  always_comb begin
    s_cyc = 1'b0;
    s_adr = '0;
    s_dat = '0;
    s_sel = '0;
    s_we  = 1'b0;
    m_ack = '0;
    m_rdt = '0;
    if (state_q == BUSY) begin
      s_cyc        = 1'b1;
      s_adr        = m_adr[gnt_q];
      s_dat        = m_dat[gnt_q];
      s_sel        = m_sel[gnt_q];
      s_we         = m_we[gnt_q];
      m_ack[gnt_q] = s_ack;
      m_rdt[gnt_q] = s_rdt;
    end
  end

  assign gnt_id   = gnt_q;
  assign wdog_err = wdog_q;

  // State registers; reset drops any grant in flight immediately.
  always_ff @(posedge clk_n or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      wcnt_q  <= '0;
      wdog_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      wcnt_q  <= wcnt_d;
      wdog_q  <= wdog_d;
    end
  end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// tb_wb_mem_arbiter: randomized cores and memory against a transaction model.
// Grants are predicted from the round-robin rule; data from a reference memory.
module tb_wb_mem_arbiter;

  localparam int NC = 6;
  localparam int TO = 8;

  logic                 clk_n = 1'b0;
  logic                 reset = 1'b1;
  logic [NC-1:0][31:2]  m_adr;
  logic [NC-1:0][31:0]  m_dat;
  logic [NC-1:0][3:0]   m_sel;
  logic [NC-1:0]        m_we;
  logic [NC-1:0]        m_cyc;
  logic [NC-1:0][31:0]  m_rdt;
  logic [NC-1:0]        m_ack;
  logic [31:2]          s_adr;
  logic [31:0]          s_dat;
  logic [3:0]           s_sel;
  logic                 s_we;
  logic                 s_cyc;
  logic [31:0]          s_rdt;
  logic                 s_ack;
  logic [2:0]           gnt_id;
  logic                 wdog_err;

  wb_mem_arbiter #(
    .NUM_CORES(NC),
    .TIMEOUT  (TO)
  ) dut (
    .clk_n   (clk_n),
    .reset   (reset),
    .m_adr   (m_adr),
    .m_dat   (m_dat),
    .m_sel   (m_sel),
    .m_we    (m_we),
    .m_cyc   (m_cyc),
    .m_rdt   (m_rdt),
    .m_ack   (m_ack),
    .s_adr   (s_adr),
    .s_dat   (s_dat),
    .s_sel   (s_sel),
    .s_we    (s_we),
    .s_cyc   (s_cyc),
    .s_rdt   (s_rdt),
    .s_ack   (s_ack),
    .gnt_id  (gnt_id),
    .wdog_err(wdog_err)
  );

  always #5 clk_n = ~clk_n;

  int vectors = 0;
  int errors  = 0;

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];

  logic [31:2] c_adr [NC];
  logic [31:0] c_dat [NC];
  logic [3:0]  c_sel [NC];
  logic        c_we  [NC];
  logic        c_cyc [NC];
  int          rem   [NC];
  bit          done  [NC];
  int          acks  [NC];
  int          waitg [NC];
  int          max_wait;
  int          gq [$];

  int          ref_ptr;
  int          cur_g;
  int          mem_wait;
  int          mem_lat;
  logic [NC-1:0] prev_req;
  bit          prev_cyc;
  bit          prev_ack;

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] dat,
    input logic [3:0]  sel
  );
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) r[b*8 +: 8] = dat[b*8 +: 8];
    end
    return r;
  endfunction

  function automatic int rr_expect(input int p, input logic [NC-1:0] r);
    int j;
    for (int k = 0; k < NC; k++) begin
      j = (p + k) % NC;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  function automatic bit pending();
    bit p;
    p = 1'b0;
    for (int i = 0; i < NC; i++) begin
      if (rem[i] > 0 || (c_cyc[i] && !done[i])) p = 1'b1;
    end
    return p;
  endfunction

  task automatic drive_cores();
    for (int i = 0; i < NC; i++) begin
      m_cyc[i] = c_cyc[i];
      m_adr[i] = c_adr[i];
      m_dat[i] = c_dat[i];
      m_sel[i] = c_sel[i];
      m_we[i]  = c_we[i];
    end
  endtask

  task automatic clear_cores();
    for (int i = 0; i < NC; i++) begin
      c_cyc[i] = 1'b0;
      c_adr[i] = '0;
      c_dat[i] = '0;
      c_sel[i] = '0;
      c_we[i]  = 1'b0;
      rem[i]   = 0;
      done[i]  = 1'b0;
      acks[i]  = 0;
      waitg[i] = 0;
    end
    max_wait = 0;
    gq.delete();
  endtask

  task automatic new_txn(input int i);
    c_cyc[i] = 1'b1;
    c_adr[i] = 30'($urandom_range(0, 255));
    c_dat[i] = $urandom;
    c_sel[i] = 4'($urandom_range(1, 15));
    c_we[i]  = 1'($urandom_range(0, 1));
    waitg[i] = 0;
  endtask

  task automatic do_reset();
    @(negedge clk_n);
    #2 reset = 1'b1;
    clear_cores();
    drive_cores();
    s_ack = 1'b0;
    s_rdt = '0;
    @(negedge clk_n);
    reset    = 1'b0;
    ref_ptr  = 0;
    cur_g    = 0;
    prev_req = '0;
    prev_cyc = 1'b0;
    prev_ack = 1'b0;
    mem_wait = 0;
    mem_lat  = 0;
  endtask

  task automatic traffic_cycle(input int pct, input int max_lat);
    logic [NC-1:0] exp_ack;
    bit            exp_cyc;
    int            eg;
    int            nz;
    logic [7:0]    wi;
    @(negedge clk_n);
    for (int i = 0; i < NC; i++) begin
      if (done[i]) begin
        done[i]  = 1'b0;
        c_cyc[i] = 1'b0;
      end
    end
    for (int i = 0; i < NC; i++) begin
      if (!c_cyc[i] && rem[i] > 0 && $urandom_range(0, 99) < pct) begin
        new_txn(i);
        rem[i]--;
      end
    end
    drive_cores();
    s_ack = 1'b0;
    s_rdt = $urandom;
    if (s_cyc) begin
      if (mem_wait >= mem_lat) begin
        s_ack = 1'b1;
        s_rdt = mem[s_adr[9:2]];
      end else begin
        mem_wait++;
      end
    end else begin
      mem_wait = 0;
      mem_lat  = $urandom_range(0, max_lat);
    end
    #1;
    exp_cyc = prev_cyc ? !prev_ack : (prev_req != '0);
    vectors++;
    if (s_cyc !== exp_cyc) begin
      errors++;
      $display("FAIL s_cyc: got %b want %b", s_cyc, exp_cyc);
    end
    if (s_cyc && !prev_cyc) begin
      eg = rr_expect(ref_ptr, prev_req);
      vectors++;
      if (int'(gnt_id) != eg) begin
        errors++;
        $display("FAIL grant: got %0d want %0d", gnt_id, eg);
      end
      cur_g = (eg < 0) ? int'(gnt_id) : eg;
    end
    exp_ack = '0;
    if (s_cyc) exp_ack[cur_g] = s_ack;
    vectors++;
    if (m_ack !== exp_ack) begin
      errors++;
      $display("FAIL m_ack: got %b want %b", m_ack, exp_ack);
    end
    vectors++;
    if (s_cyc) begin
      if ({s_adr, s_dat, s_sel, s_we} !==
          {c_adr[cur_g], c_dat[cur_g], c_sel[cur_g], c_we[cur_g]}) begin
        errors++;
        $display("FAIL s_bus: got %h/%h/%h/%b want %h/%h/%h/%b",
                 s_adr, s_dat, s_sel, s_we,
                 c_adr[cur_g], c_dat[cur_g], c_sel[cur_g], c_we[cur_g]);
      end
    end else begin
      if ({s_adr, s_dat, s_sel, s_we} !== '0) begin
        errors++;
        $display("FAIL s_idle: got %h/%h/%h/%b want 0",
                 s_adr, s_dat, s_sel, s_we);
      end
    end
    nz = 0;
    for (int i = 0; i < NC; i++) begin
      if ((!s_cyc || i != cur_g) && m_rdt[i] !== 32'h0) nz++;
    end
    vectors++;
    if (nz != 0) begin
      errors++;
      $display("FAIL m_rdt_others: got %0d nonzero want 0", nz);
    end
    if (s_cyc && s_ack) begin
      wi = c_adr[cur_g][9:2];
      if (!c_we[cur_g]) begin
        vectors++;
        if (m_rdt[cur_g] !== ref_mem[wi]) begin
          errors++;
          $display("FAIL rdata: got %h want %h", m_rdt[cur_g], ref_mem[wi]);
        end
      end else begin
        ref_mem[wi] = merge(ref_mem[wi], c_dat[cur_g], c_sel[cur_g]);
        mem[s_adr[9:2]] = merge(mem[s_adr[9:2]], s_dat, s_sel);
      end
      acks[cur_g]++;
      gq.push_back(cur_g);
      done[cur_g] = 1'b1;
      ref_ptr = (cur_g + 1) % NC;
      for (int i = 0; i < NC; i++) begin
        if (i != cur_g && c_cyc[i]) begin
          waitg[i]++;
          if (waitg[i] > max_wait) max_wait = waitg[i];
        end
      end
      waitg[cur_g] = 0;
    end
    prev_req = m_cyc;
    prev_cyc = s_cyc;
    prev_ack = s_cyc && s_ack;
  endtask

  task automatic run_traffic(input int pct, input int max_lat, input int budget);
    int n;
    n = 0;
    while (n < budget && pending()) begin
      traffic_cycle(pct, max_lat);
      n++;
    end
    traffic_cycle(0, 0);
    traffic_cycle(0, 0);
    vectors++;
    if (n >= budget) begin
      errors++;
      $display("FAIL traffic_budget: got %0d cycles want < %0d", n, budget);
    end
  endtask

  task automatic test_reset();
    clear_cores();
    drive_cores();
    s_ack = 1'b0;
    s_rdt = '0;
    #1;
    vectors++;
    if (s_cyc !== 1'b0) begin
      errors++;
      $display("FAIL rst_s_cyc: got %b want 0", s_cyc);
    end
    vectors++;
    if ({s_adr, s_dat, s_sel, s_we} !== '0) begin
      errors++;
      $display("FAIL rst_s_bus: got %h/%h/%h/%b want 0", s_adr, s_dat, s_sel, s_we);
    end
    vectors++;
    if (m_ack !== '0) begin
      errors++;
      $display("FAIL rst_m_ack: got %b want 0", m_ack);
    end
    vectors++;
    if (m_rdt !== '0) begin
      errors++;
      $display("FAIL rst_m_rdt: got %h want 0", m_rdt);
    end
    vectors++;
    if (gnt_id !== 3'd0) begin
      errors++;
      $display("FAIL rst_gnt_id: got %0d want 0", gnt_id);
    end
    vectors++;
    if (wdog_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_wdog: got %b want 0", wdog_err);
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    @(negedge clk_n);
    s_ack = 1'b1;
    #1;
    vectors++;
    if (m_ack !== '0 || s_cyc !== 1'b0) begin
      errors++;
      $display("FAIL idle_ack: got ack %b cyc %b want 0 0", m_ack, s_cyc);
    end
    @(negedge clk_n);
    s_ack    = 1'b0;
    c_cyc[2] = 1'b1;
    c_adr[2] = 30'h40;
    c_dat[2] = 32'hDEADBEEF;
    c_sel[2] = 4'hF;
    c_we[2]  = 1'b1;
    drive_cores();
    #1;
    vectors++;
    if (s_cyc !== 1'b0) begin
      errors++;
      $display("FAIL single_early: got %b want 0", s_cyc);
    end
    @(negedge clk_n);
    s_ack = 1'b1;
    #1;
    vectors++;
    if (s_cyc !== 1'b1 || gnt_id !== 3'd2) begin
      errors++;
      $display("FAIL single_grant: got cyc %b gnt %0d want 1 2", s_cyc, gnt_id);
    end
    vectors++;
    if (m_ack !== 6'b000100) begin
      errors++;
      $display("FAIL single_ack: got %b want 000100", m_ack);
    end
    if (s_ack && s_cyc && s_we) begin
      mem[s_adr[9:2]] = merge(mem[s_adr[9:2]], s_dat, s_sel);
    end
    ref_mem[8'h40] = 32'hDEADBEEF;
    vectors++;
    if (mem[8'h40] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_mem: got %h want deadbeef", mem[8'h40]);
    end
    @(negedge clk_n);
    s_ack = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      c_cyc[i] = 1'b1;
      c_adr[i] = 30'(i);
      c_we[i]  = 1'b0;
    end
    drive_cores();
    #1;
    vectors++;
    if (s_cyc !== 1'b0 || m_ack !== '0) begin
      errors++;
      $display("FAIL single_gap: got cyc %b ack %b want 0 0", s_cyc, m_ack);
    end
    @(negedge clk_n);
    s_ack = 1'b1;
    #1;
    vectors++;
    if (gnt_id !== 3'd3 || m_ack !== 6'b001000) begin
      errors++;
      $display("FAIL single_ptr: got gnt %0d ack %b want 3 001000", gnt_id, m_ack);
    end
    @(negedge clk_n);
    s_ack = 1'b0;
    clear_cores();
    drive_cores();
  endtask

  task automatic test_contention();
    do_reset();
    rem[0] = 1;
    rem[1] = 1;
    rem[5] = 1;
    run_traffic(100, 2, 200);
    vectors++;
    if (gq.size() != 3 || gq[0] != 0 || gq[1] != 1 || gq[2] != 5) begin
      errors++;
      $display("FAIL contention_order: got %p want 0 1 5", gq);
    end
    for (int i = 0; i < NC; i++) begin
      vectors++;
      if (acks[i] != ((i == 0 || i == 1 || i == 5) ? 1 : 0)) begin
        errors++;
        $display("FAIL contention_acks[%0d]: got %0d", i, acks[i]);
      end
    end
  endtask

  task automatic test_rotation();
    do_reset();
    for (int i = 0; i < NC; i++) rem[i] = 10;
    run_traffic(100, 1, 2000);
    for (int i = 0; i < NC; i++) begin
      vectors++;
      if (acks[i] != 10) begin
        errors++;
        $display("FAIL rotation_acks[%0d]: got %0d want 10", i, acks[i]);
      end
    end
    vectors++;
    if (max_wait > NC - 1 || gq.size() != 60) begin
      errors++;
      $display("FAIL rotation_fair: got wait %0d grants %0d want <=5 60",
               max_wait, gq.size());
    end
  endtask

  task automatic test_random();
    int want [NC];
    do_reset();
    for (int i = 0; i < NC; i++) begin
      want[i] = $urandom_range(0, 6);
      rem[i]  = want[i];
    end
    run_traffic(35, 3, 3000);
    for (int i = 0; i < NC; i++) begin
      vectors++;
      if (acks[i] != want[i]) begin
        errors++;
        $display("FAIL random_acks[%0d]: got %0d want %0d", i, acks[i], want[i]);
      end
    end
  endtask

  task automatic test_abort();
    do_reset();
    @(negedge clk_n);
    c_cyc[3] = 1'b1;
    c_cyc[4] = 1'b1;
    c_adr[3] = 30'h33;
    c_adr[4] = 30'h44;
    drive_cores();
    @(negedge clk_n);
    #1;
    vectors++;
    if (s_cyc !== 1'b1 || gnt_id !== 3'd3) begin
      errors++;
      $display("FAIL abort_grant: got cyc %b gnt %0d want 1 3", s_cyc, gnt_id);
    end
    @(negedge clk_n);
    c_cyc[3] = 1'b0;
    drive_cores();
    #1;
    vectors++;
    if (m_ack !== '0) begin
      errors++;
      $display("FAIL abort_ack: got %b want 0", m_ack);
    end
    @(negedge clk_n);
    #1;
    vectors++;
    if (s_cyc !== 1'b0 || m_ack !== '0) begin
      errors++;
      $display("FAIL abort_drop: got cyc %b ack %b want 0 0", s_cyc, m_ack);
    end
    @(negedge clk_n);
    s_ack = 1'b1;
    #1;
    vectors++;
    if (gnt_id !== 3'd4 || m_ack !== 6'b010000 || s_adr !== 30'h44) begin
      errors++;
      $display("FAIL abort_next: got gnt %0d ack %b adr %h want 4 010000 44",
               gnt_id, m_ack, s_adr);
    end
    @(negedge clk_n);
    s_ack = 1'b0;
    clear_cores();
    drive_cores();
  endtask

  task automatic test_watchdog();
    int busy;
    int n;
    int drops;
    bit seen_ack;
    bit early;
    do_reset();
    @(negedge clk_n);
    c_cyc[1] = 1'b1;
    c_adr[1] = 30'h15;
    c_sel[1] = 4'hF;
    drive_cores();
    busy     = 0;
    n        = 0;
    seen_ack = 1'b0;
    early    = 1'b0;
    do begin
      @(negedge clk_n);
      #1;
      n++;
    end while (!s_cyc && n < 5);
    while (s_cyc && n < 40) begin
      busy++;
      if (m_ack !== '0) seen_ack = 1'b1;
      if (wdog_err !== 1'b0) early = 1'b1;
      @(negedge clk_n);
      #1;
      n++;
    end
    vectors++;
    if (busy != TO) begin
      errors++;
      $display("FAIL wdog_busy: got %0d cycles want %0d", busy, TO);
    end
    vectors++;
    if (early || seen_ack) begin
      errors++;
      $display("FAIL wdog_early: got early %b ack %b want 0 0", early, seen_ack);
    end
    vectors++;
    if (wdog_err !== 1'b1 || s_cyc !== 1'b0) begin
      errors++;
      $display("FAIL wdog_fire: got err %b cyc %b want 1 0", wdog_err, s_cyc);
    end
    drops = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_n);
      #1;
      if (wdog_err !== 1'b1) drops++;
    end
    vectors++;
    if (drops != 0) begin
      errors++;
      $display("FAIL wdog_sticky: got %0d drops want 0", drops);
    end
    do_reset();
    #1;
    vectors++;
    if (wdog_err !== 1'b0) begin
      errors++;
      $display("FAIL wdog_clear: got %b want 0", wdog_err);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk_n);
    c_cyc[4] = 1'b1;
    c_adr[4] = 30'h4;
    drive_cores();
    @(negedge clk_n);
    #1;
    vectors++;
    if (s_cyc !== 1'b1 || gnt_id !== 3'd4) begin
      errors++;
      $display("FAIL mid_grant: got cyc %b gnt %0d want 1 4", s_cyc, gnt_id);
    end
    @(negedge clk_n);
    #2 reset = 1'b1;
    s_ack = 1'b1;
    #1;
    vectors++;
    if ({s_cyc, s_adr, s_dat, s_sel, s_we} !== '0 ||
        m_ack !== '0 || m_rdt !== '0 || gnt_id !== 3'd0) begin
      errors++;
      $display("FAIL mid_reset: got cyc %b ack %b gnt %0d want 0 0 0",
               s_cyc, m_ack, gnt_id);
    end
    @(negedge clk_n);
    s_ack    = 1'b0;
    c_cyc[0] = 1'b1;
    c_adr[0] = 30'h10;
    drive_cores();
    reset = 1'b0;
    @(negedge clk_n);
    s_ack = 1'b1;
    #1;
    vectors++;
    if (gnt_id !== 3'd0 || m_ack !== 6'b000001) begin
      errors++;
      $display("FAIL mid_first: got gnt %0d ack %b want 0 000001", gnt_id, m_ack);
    end
    @(negedge clk_n);
    s_ack    = 1'b0;
    c_cyc[0] = 1'b0;
    drive_cores();
    @(negedge clk_n);
    #1;
    vectors++;
    if (s_cyc !== 1'b1 || gnt_id !== 3'd4) begin
      errors++;
      $display("FAIL mid_second: got cyc %b gnt %0d want 1 4", s_cyc, gnt_id);
    end
    clear_cores();
    drive_cores();
  endtask

  task automatic test_mem_image();
    int nbad;
    nbad = 0;
    for (int i = 0; i < 256; i++) begin
      if (mem[i] !== ref_mem[i]) nbad++;
    end
    vectors++;
    if (nbad != 0) begin
      errors++;
      $display("FAIL mem_image: got %0d bad words want 0", nbad);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    test_reset();
    test_single();
    test_contention();
    test_rotation();
    test_random();
    test_abort();
    test_watchdog();
    test_reset_mid();
    test_mem_image();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
